// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl
// Sequencer for an iterative AES-128 decryptor.
// The key store and the inverse-round datapath sit outside this block. This
// block owns the 128-bit state register and the round counter. It selects the
// round key and the InvMixColumns enable for every step. It accepts ciphertext
// and presents plaintext over ready/valid handshakes.
//
// Optional feature: define AES_DEC_ABORT_EN to add the synchronous 'abort'
// input. Abort cancels a block that is in progress. Without the macro the port
// and its logic are not built.
//
// Flow of one block:
//   IDLE  : rk_addr=10. At accept, state <= in_data ^ rk_data (whitening with
//           round key 10). The counter is loaded with 9.
//   ROUND : rk_addr=counter, dp_mix=1. This state lasts 9 cycles, for
//           counter values 9 down to 1.
//   FINAL : rk_addr=0, dp_mix=0. This state lasts 1 cycle.
//   DONE  : out_valid=1. The block waits here for out_ready.
// out_valid is therefore high in the 11th cycle after the accept cycle.

module aes_dec_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  // ciphertext input
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  // plaintext output
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  // external round-key store (asynchronous read)
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  // external inverse-round datapath
  output logic [127:0] dp_state,
  output logic         dp_mix,
  input  logic [127:0] dp_result
`ifdef AES_DEC_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_KEY_IDX  = 4'd10;
  localparam logic [3:0] FIRST_ROUND   = 4'd9;
  localparam logic [3:0] FIRST_KEY_IDX = 4'd0;

  state_t       r_fsm;
  state_t       w_fsm_next;
  logic [127:0] r_state;
  logic [127:0] w_state_next;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_next;
  logic         w_cnt_illegal;

  // Counter values above 10 can only come from an upset. Such a value sends
  // the FSM back to IDLE and is never used as a key index.
  assign w_cnt_illegal = (r_cnt > LAST_KEY_IDX);

`ifdef AES_DEC_ABORT_EN
  logic w_abort;
  // Abort only acts while a block is being processed. It is ignored in IDLE
  // and DONE.
  assign w_abort = abort && ((r_fsm == S_ROUND) || (r_fsm == S_FINAL));
`endif

  // The state register drives the datapath and the plaintext output directly.
  assign dp_state = r_state;
  assign out_data = r_state;

  // Next-state, datapath-load and handshake decode for the round sequencer
  always_comb begin
    w_fsm_next   = r_fsm;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    rk_addr      = LAST_KEY_IDX;
    dp_mix       = 1'b0;

    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Initial AddRoundKey uses key 10, which is already on rk_addr.
          w_state_next = in_data ^ rk_data;
          w_cnt_next   = FIRST_ROUND;
          w_fsm_next   = S_ROUND;
        end
      end

      S_ROUND: begin
        rk_addr      = w_cnt_illegal ? LAST_KEY_IDX : r_cnt;
        dp_mix       = 1'b1;
        w_state_next = dp_result;
        if (r_cnt <= 4'd1) begin
          // Round 1 was the last full round. The counter stops at 0 and
          // never wraps.
          w_cnt_next = 4'd0;
          w_fsm_next = S_FINAL;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end

      S_FINAL: begin
        rk_addr      = FIRST_KEY_IDX;
        w_state_next = dp_result;
        w_fsm_next   = S_DONE;
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_next = S_IDLE;
        end
      end

      default: begin
        w_fsm_next = S_IDLE;
      end
    endcase

`ifdef AES_DEC_ABORT_EN
    // A cancelled block leaves no trace in the state register.
    if (w_abort) begin
      w_fsm_next   = S_IDLE;
      w_state_next = '0;
      w_cnt_next   = 4'd0;
    end
`endif

    // Recovery from an unreachable counter value.
    if (w_cnt_illegal) begin
      w_fsm_next = S_IDLE;
      w_cnt_next = 4'd0;
    end
  end

  // State register, round counter and FSM. Reset clears them immediately,
  // without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_cnt   <= 4'd0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb_aes_dec_round_ctrl
// The bench supplies the environment of the sequencer:
//  - a FIPS-197 key store for key 000102..0f, read asynchronously;
//  - a combinational inverse-round datapath.
// A cycle-level reference model is written from the handshake and latency
// rules. It is checked against the DUT on every falling edge. The AES tables
// and the reference decryption are pinned by FIPS-197 literals.
`timescale 1ns/1ps

module tb_aes_dec_round_ctrl;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] dp_state;
  logic         dp_mix;
  logic [127:0] dp_result;
`ifdef AES_DEC_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [11];

  always #5 clk = ~clk;

  aes_dec_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .dp_state  (dp_state),
    .dp_mix    (dp_mix),
    .dp_result (dp_result)
`ifdef AES_DEC_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse and the affine map; FIPS-197 key schedule.
  task automatic build_tables();
    logic [7:0]  inv;
    logic [7:0]  s;
    logic [7:0]  c;
    logic [7:0]  rc;
    logic [31:0] t;
    logic [31:0] w [44];
    logic [127:0] key;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    key = KEY;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // InvShiftRows, InvSubBytes, AddRoundKey, then optionally InvMixColumns.
  function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] k, input logic mix);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = st[127 - 8 * i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r + 4 * c] = isbox[a[r + 4 * ((c - r + 4) % 4)]];
    for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127 - 8 * i -: 8];
    for (int c = 0; c < 4; c++) begin
      x0 = b[4 * c]; x1 = b[4 * c + 1]; x2 = b[4 * c + 2]; x3 = b[4 * c + 3];
      if (mix) begin
        a[4 * c]     = gm(x0, 8'h0e) ^ gm(x1, 8'h0b) ^ gm(x2, 8'h0d) ^ gm(x3, 8'h09);
        a[4 * c + 1] = gm(x0, 8'h09) ^ gm(x1, 8'h0e) ^ gm(x2, 8'h0b) ^ gm(x3, 8'h0d);
        a[4 * c + 2] = gm(x0, 8'h0d) ^ gm(x1, 8'h09) ^ gm(x2, 8'h0e) ^ gm(x3, 8'h0b);
        a[4 * c + 3] = gm(x0, 8'h0b) ^ gm(x1, 8'h0d) ^ gm(x2, 8'h09) ^ gm(x3, 8'h0e);
      end else begin
        a[4 * c] = x0; a[4 * c + 1] = x1; a[4 * c + 2] = x2; a[4 * c + 3] = x3;
      end
    end
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = a[i];
    return o;
  endfunction

  // FIPS-197 inverse cipher for AES-128.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] st;
    st = ct ^ rk[10];
    for (int r = 9; r >= 1; r--) st = inv_round(st, rk[r], 1'b1);
    return inv_round(st, rk[0], 1'b0);
  endfunction

  // ---------------- environment: key store and datapath ----------------
  assign rk_data = (rk_addr <= 4'd10) ? rk[rk_addr] : '0;

  always_comb begin
    dp_result = inv_round(dp_state, rk_data, dp_mix);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model.
  // m_age is the cycle index after accept: 1..9 are the full rounds, 10 is
  // the last round, and 11 means the plaintext is on offer.
  logic         m_busy;
  int           m_age;
  logic [127:0] m_pt;
  logic [127:0] m_init;
  logic [127:0] m_out;
  logic         m_out_known;

  // Model update, sampling the bench inputs at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy      <= 1'b0;
      m_age       <= 0;
      m_out       <= '0;
      m_out_known <= 1'b1;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy      <= 1'b1;
        m_age       <= 1;
        m_pt        <= ref_decrypt(in_data);
        m_init      <= in_data ^ rk[10];
        m_out_known <= 1'b0;
      end
    end
`ifdef AES_DEC_ABORT_EN
    else if (abort && m_age <= 10) begin
      m_busy      <= 1'b0;
      m_age       <= 0;
      m_out       <= '0;
      m_out_known <= 1'b1;
    end
`endif
    else if (m_age < 11) begin
      m_age <= m_age + 1;
      if (m_age == 10) begin
        m_out       <= m_pt;
        m_out_known <= 1'b1;
      end
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end
  end

  function automatic int exp_rk(input logic busy, input int age);
    if (!busy) return 10;
    if (age <= 9) return 10 - age;
    if (age == 10) return 0;
    return 10;
  endfunction

  // Per-cycle compare, on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {127'd0, in_ready}, {127'd0, !m_busy});
      chk("out_valid", {127'd0, out_valid}, {127'd0, (m_busy && m_age == 11)});
      chk("rk_addr", {124'd0, rk_addr}, 128'(exp_rk(m_busy, m_age)));
      chk("dp_mix", {127'd0, dp_mix}, {127'd0, (m_busy && m_age <= 9)});
      if (m_busy && m_age == 1) chk("state_after_accept", dp_state, m_init);
      if (m_out_known) chk("out_data", out_data, m_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1) begin
        step();
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  // Count cycles from the accept until out_valid. The accept cycle is cycle 0.
  task automatic wait_out(output int lat, input bit junk);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (junk) begin
        in_valid  = 1'($urandom % 2);
        in_data   = rnd128();
        out_ready = 1'($urandom % 2);
      end
      step();
      lat++;
    end
  endtask

  task automatic run_block(input logic [127:0] ct);
    bit ok;
    int lat;
    in_data  = ct;
    in_valid = 1'b1;
    wait_accept(ok);
    chk("accept", {127'd0, ok}, 128'd1);
    wait_out(lat, 1'b1);
    chk("latency", 128'(lat), 128'd11);
    in_valid = 1'b0;
    for (int g = 0; g < 40; g++) begin
      out_ready = 1'($urandom % 2);
      step();
      if (out_ready) break;
    end
    out_ready = 1'b0;
    repeat ($urandom % 3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    logic [127:0] held;
    logic [127:0] blk_b;

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef AES_DEC_ABORT_EN
    abort     = 1'b0;
`endif
    build_tables();

    // Reset takes effect asynchronously, before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_rk_addr", {124'd0, rk_addr}, 128'd10);
    chk("rst_dp_mix", {127'd0, dp_mix}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);

    // Pin the model to FIPS-197.
    chk("sbox_00", {120'd0, sbox[0]}, 128'h63);
    chk("sbox_53", {120'd0, sbox[8'h53]}, 128'hed);
    chk("rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_fips", ref_decrypt(CT), PT);

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // FIPS vector. out_ready is held low in DONE while in_valid pulses.
    in_data  = CT;
    in_valid = 1'b1;
    wait_accept(ok);
    chk("fips_accept", {127'd0, ok}, 128'd1);
    wait_out(lat, 1'b0);
    chk("fips_latency", 128'(lat), 128'd11);
    chk("fips_pt", out_data, PT);
    held = out_data;
    repeat (5) begin
      in_valid = 1'b1;
      in_data  = rnd128();
`ifdef AES_DEC_ABORT_EN
      abort    = 1'b1;
`endif
      step();
      chk("hold_valid", {127'd0, out_valid}, 128'd1);
      chk("hold_data", out_data, held);
    end
`ifdef AES_DEC_ABORT_EN
    abort     = 1'b0;
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("idle_after_hs", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b0;
    step();

    // Back-to-back blocks. B waits on in_valid and is taken right after
    // A's output handshake.
    blk_b     = rnd128();
    in_data   = rnd128();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_accept(ok);
    chk("b2b_accept_a", {127'd0, ok}, 128'd1);
    in_data = blk_b;
    wait_out(lat, 1'b0);
    chk("b2b_latency_a", 128'(lat), 128'd11);
    step();
    chk("b2b_ready", {127'd0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    wait_out(lat, 1'b0);
    chk("b2b_latency_b", 128'(lat), 128'd11);
    chk("b2b_pt_b", out_data, ref_decrypt(blk_b));
    step();
    out_ready = 1'b0;

    // Random blocks with random back-pressure and junk on in_valid/in_data.
    for (int n = 0; n < 15; n++) run_block(rnd128());

    // Asynchronous reset at ROUND counter=5.
    in_data  = rnd128();
    in_valid = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    repeat (4) step();
    chk("rk_at_5", {124'd0, rk_addr}, 128'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rr_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rr_rk_addr", {124'd0, rk_addr}, 128'd10);
    chk("rr_dp_mix", {127'd0, dp_mix}, 128'd0);
    chk("rr_state", out_data, 128'd0);
    step();
    rst_n = 1'b1;
    step();
    run_block(CT);

    // Asynchronous reset while the plaintext is on offer.
    in_data  = rnd128();
    in_valid = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    wait_out(lat, 1'b0);
    chk("rd_valid_before", {127'd0, out_valid}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rd_valid_drop", {127'd0, out_valid}, 128'd0);
    chk("rd_state", out_data, 128'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef AES_DEC_ABORT_EN
    // Abort at counter=3. The next cycle is IDLE with a cleared state
    // register, and no output is produced for this block.
    in_data  = rnd128();
    in_valid = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    repeat (6) step();
    chk("rk_at_3", {124'd0, rk_addr}, 128'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_in_ready", {127'd0, in_ready}, 128'd1);
    chk("ab_out_valid", {127'd0, out_valid}, 128'd0);
    chk("ab_state", dp_state, 128'd0);
    repeat (12) step();
    run_block(CT);
`endif

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
